// File: rtl/encoder_proj.sv
// Hamming(7,4) encoder with a small nibble FIFO and a UART-style serializer:
// start bit, cw[0]..cw[6] LSB first, stop bit, each held BIT_DIV clocks.
module encoder_proj #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned BIT_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       err_en,
  input  logic [2:0] err_pos,
  output logic       tx_out,
  output logic       tx_busy,
  output logic [6:0] cw_last
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  DIV_LAST = 8'(BIT_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          run;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;
  logic [6:0]    flip;
  logic [6:0]    rd_word;
  logic [7:0]    div_cnt;
  logic [2:0]    bit_idx;
  logic [6:0]    shreg;
  logic          bit_end;

  function automatic logic [6:0] hamming(input logic [3:0] d);
    hamming = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
               d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  // FSM is held in IDLE until reset release has passed through two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign data_ready = (count != (AW + 1)'(DEPTH));
  assign wr_en      = data_valid & data_ready;
  assign rd_en      = run & (state == IDLE) & (count != '0);
  assign flip       = (err_en && err_pos != 3'd7) ? (7'(1) << err_pos) : '0;
  assign rd_word    = hamming(mem[rd_ptr]) ^ flip;
  assign bit_end    = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Current data bit always sits in shreg[0]; tx_out is loaded one bit ahead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      cw_last <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en) begin
            shreg   <= rd_word;
            cw_last <= rd_word;
            div_cnt <= '0;
            bit_idx <= '0;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            tx_out  <= shreg[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_idx == 3'd6) begin
              bit_idx <= '0;
              tx_out  <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[6:1]};
              tx_out  <= shreg[1];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_proj.sv
// Bench for encoder_proj: scoreboard of expected codewords checked against a
// serial-line monitor, plus directed checks on a BIT_DIV=1 instance.
module tb_encoder_proj;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] cw;
    bit         clean;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       err_en;
  logic [2:0] err_pos;
  logic       tx_out;
  logic       tx_busy;
  logic [6:0] cw_last;

  logic [3:0] data_in1;
  logic       data_valid1;
  logic       data_ready1;
  logic       tx_out1;
  logic       tx_busy1;
  logic [6:0] cw_last1;

  int   n_total = 0;
  int   n_pass  = 0;
  int   pcyc    = 0;
  exp_t exp_q[$];
  int   starts[$];

  encoder_proj #(.DEPTH(4), .BIT_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .err_en(err_en), .err_pos(err_pos),
    .tx_out(tx_out), .tx_busy(tx_busy), .cw_last(cw_last)
  );

  encoder_proj #(.DEPTH(4), .BIT_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in1), .data_valid(data_valid1),
    .data_ready(data_ready1), .err_en(1'b0), .err_pos(3'd0),
    .tx_out(tx_out1), .tx_busy(tx_busy1), .cw_last(cw_last1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) pcyc++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  // Serial monitor on the BIT_DIV=8 instance: samples every bit cell at each
  // negedge, pops the scoreboard and checks frame shape, payload and gap.
  initial begin : mon
    logic [8:0] fr;
    bit         bad;
    bit         abort;
    bit         have_e;
    exp_t       e;
    logic [6:0] rx;
    logic [2:0] syn;
    forever begin
      @(negedge clk);
      if (rst_n && tx_busy) begin
        starts.push_back(pcyc);
        bad   = 0;
        abort = 0;
        for (int k = 0; k < 9 && !abort; k++) begin
          for (int c = 0; c < 8 && !abort; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (!rst_n) abort = 1;
            else begin
              if (c == 0) fr[k] = tx_out;
              else if (tx_out !== fr[k]) bad = 1;
              if (tx_busy !== 1'b1) bad = 1;
            end
          end
        end
        if (abort) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          rx     = fr[7:1];
          have_e = exp_q.size() > 0;
          n_total++;
          if (!have_e) begin
            $display("FAIL frame_unexpected: got cw=%b, required no frame", rx);
          end else begin
            e = exp_q.pop_front();
            if (bad || fr[0] !== 1'b0 || fr[8] !== 1'b1 || rx !== e.cw)
              $display("FAIL frame: got bits=%b unstable=%0d, required start=0 cw=%b stop=1",
                       fr, bad, e.cw);
            else n_pass++;
          end
          if (have_e && e.clean) begin
            syn[0] = rx[0] ^ rx[2] ^ rx[4] ^ rx[6];
            syn[1] = rx[1] ^ rx[2] ^ rx[5] ^ rx[6];
            syn[2] = rx[3] ^ rx[4] ^ rx[5] ^ rx[6];
            n_total++;
            if (syn !== 3'b000 || {rx[6], rx[5], rx[4], rx[2]} !== e.nib)
              $display("FAIL decode: got syndrome=%b nibble=%h, required syndrome=000 nibble=%h",
                       syn, {rx[6], rx[5], rx[4], rx[2]}, e.nib);
            else n_pass++;
          end
          @(negedge clk);
          if (rst_n) begin
            n_total++;
            if (tx_busy !== 1'b0 || tx_out !== 1'b1)
              $display("FAIL idle_gap: got busy=%b tx=%b, required busy=0 tx=1", tx_busy, tx_out);
            else n_pass++;
          end
        end
      end
    end
  end

  task automatic put(input logic [3:0] n, input logic [6:0] cw, input bit clean);
    int   g = 0;
    exp_t e;
    @(negedge clk);
    while (!data_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!data_ready) begin
      n_total++;
      $display("FAIL put_timeout: got ready=%b, required 1", data_ready);
    end else begin
      data_in    = n;
      data_valid = 1'b1;
      e.nib = n; e.cw = cw; e.clean = clean;
      exp_q.push_back(e);
      @(negedge clk);
      data_valid = 1'b0;
    end
  endtask

  task automatic wait_busy();
    int g = 0;
    while (!tx_busy && g < 20) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int g = 0;
    while ((exp_q.size() != 0 || tx_busy) && g < budget) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0 || tx_busy)
      $display("FAIL drain_%s: got pending=%0d busy=%b, required 0 and 0", tag, exp_q.size(), tx_busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_valid = 1'b0; data_in = '0; err_en = 1'b0; err_pos = '0;
    data_valid1 = 1'b0; data_in1 = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || data_ready !== 1'b1 || cw_last !== 7'b0)
      $display("FAIL reset_state: got tx=%b busy=%b ready=%b cw=%b, required 1 0 1 0000000",
               tx_out, tx_busy, data_ready, cw_last);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (tx_busy !== 1'b0 || tx_out !== 1'b1)
      $display("FAIL reset_release: got busy=%b tx=%b, required 0 1", tx_busy, tx_out);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int hi = 1;
    put(4'b1011, 7'b1010101, 1);
    wait_busy();
    n_total++;
    if (cw_last !== 7'b1010101)
      $display("FAIL single_cw: got %b, required 1010101", cw_last);
    else n_pass++;
    while (tx_busy && hi < 200) begin
      @(negedge clk);
      if (tx_busy) hi++;
    end
    n_total++;
    if (hi !== 72) $display("FAIL single_busy_len: got %0d cycles, required 72", hi);
    else n_pass++;
    drain(100, "single");
  endtask

  task automatic test_extremes();
    put(4'h0, 7'b0000000, 1);
    wait_busy();
    n_total++;
    if (cw_last !== 7'b0000000) $display("FAIL cw_zero: got %b, required 0000000", cw_last);
    else n_pass++;
    drain(100, "zero");
    put(4'hF, 7'b1111111, 1);
    wait_busy();
    n_total++;
    if (cw_last !== 7'b1111111) $display("FAIL cw_ones: got %b, required 1111111", cw_last);
    else n_pass++;
    drain(100, "ones");
  endtask

  task automatic test_all16();
    for (int i = 0; i < 16; i++) put(4'(i), enc(4'(i)), 1);
    drain(16 * 80, "all16");
  endtask

  task automatic test_error();
    logic [2:0] pos [3];
    logic [6:0] want [3];
    pos[0] = 3'd3; want[0] = 7'b1011101;
    pos[1] = 3'd7; want[1] = 7'b1010101;
    pos[2] = 3'd6; want[2] = 7'b0010101;
    for (int i = 0; i < 3; i++) begin
      err_en  = 1'b1;
      err_pos = pos[i];
      put(4'b1011, want[i], pos[i] == 3'd7);
      wait_busy();
      err_en = 1'b0;
      n_total++;
      if (cw_last !== want[i])
        $display("FAIL err_inject_pos%0d: got %b, required %b", pos[i], cw_last, want[i]);
      else n_pass++;
      drain(100, "err");
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] nib [6];
    exp_t e;
    nib[0] = 4'h3; nib[1] = 4'hA; nib[2] = 4'h6; nib[3] = 4'hC; nib[4] = 4'h9; nib[5] = 4'h1;
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_total++;
      if (data_ready !== (i < 5))
        $display("FAIL b2b_ready_%0d: got %b, required %b", i, data_ready, i < 5);
      else n_pass++;
      data_in    = nib[i];
      data_valid = 1'b1;
      if (i < 5) begin
        e.nib = nib[i]; e.cw = enc(nib[i]); e.clean = 1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    drain(6 * 80, "b2b");
    n_total++;
    if (starts.size() !== 5) $display("FAIL b2b_frames: got %0d, required 5", starts.size());
    else n_pass++;
    for (int i = 1; i < starts.size(); i++) begin
      n_total++;
      if (starts[i] - starts[i-1] !== 73)
        $display("FAIL b2b_period_%0d: got %0d, required 73", i, starts[i] - starts[i-1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    starts.delete();
    put(4'b1011, 7'b1010101, 1);
    put(4'h5, enc(4'h5), 1);
    while (starts.size() == 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_total++;
    if (starts.size() == 0) begin
      $display("FAIL mid_start: got no frame, required one");
    end else begin
      n_pass++;
      // frame cell 36 = middle of data bit 3
      while (pcyc < starts[0] + 36) @(negedge clk);
    end
    n_total++;
    if (tx_busy !== 1'b1) $display("FAIL mid_busy: got %b, required 1", tx_busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || data_ready !== 1'b1 || cw_last !== 7'b0)
      $display("FAIL mid_reset: got tx=%b busy=%b ready=%b cw=%b, required 1 0 1 0000000",
               tx_out, tx_busy, data_ready, cw_last);
    else n_pass++;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    g = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_busy) g++;
    end
    n_total++;
    if (g !== 0) $display("FAIL mid_fifo_empty: got %0d busy cycles, required 0", g);
    else n_pass++;
    put(4'b0110, enc(4'b0110), 1);
    drain(100, "after_reset");
  endtask

  task automatic test_bitdiv1();
    logic [3:0] nib1 [6];
    nib1[0] = 4'h1; nib1[1] = 4'h2; nib1[2] = 4'h4; nib1[3] = 4'h8; nib1[4] = 4'hD; nib1[5] = 4'h7;
    fork
      begin
        int i = 0;
        int g = 0;
        while (i < 6 && g < 300) begin
          @(negedge clk);
          g++;
          if (data_ready1) begin
            data_valid1 = 1'b1;
            data_in1    = nib1[i];
            i++;
          end else begin
            data_valid1 = 1'b0;
          end
        end
        @(negedge clk);
        data_valid1 = 1'b0;
      end
      begin
        int rises  = 0;
        int prev_t = 0;
        int hi     = 0;
        bit pb     = 0;
        for (int c = 0; c < 400 && rises < 6; c++) begin
          @(negedge clk);
          if (!tx_busy1 && pb) begin
            n_total++;
            if (hi !== 9) $display("FAIL bd1_busy_len: got %0d, required 9", hi);
            else n_pass++;
          end
          if (tx_busy1 && !pb) begin
            n_total++;
            if (cw_last1 !== enc(nib1[rises]))
              $display("FAIL bd1_cw_%0d: got %b, required %b", rises, cw_last1, enc(nib1[rises]));
            else n_pass++;
            if (rises > 0) begin
              n_total++;
              if (pcyc - prev_t !== 10)
                $display("FAIL bd1_period_%0d: got %0d, required 10", rises, pcyc - prev_t);
              else n_pass++;
            end
            prev_t = pcyc;
            rises++;
            hi = 0;
          end
          if (tx_busy1) hi++;
          pb = tx_busy1;
        end
        n_total++;
        if (rises !== 6) $display("FAIL bd1_frames: got %0d, required 6", rises);
        else n_pass++;
      end
    join
    repeat (15) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_all16();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_bitdiv1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/encoder_proj.md
ENCODER_PROJ -- requirements
Module: encoder_proj

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving input FIFO depth in nibbles (power of two, 2..16).
REQ-002 The block SHALL have parameter BIT_DIV, default 8, giving clock cycles per serial bit (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port data_in, input, 4 bits, nibble to encode (d3..d0).
REQ-006 The block SHALL have port data_valid, input, 1 bit, data_in valid this cycle.
REQ-007 The block SHALL have port data_ready, output, 1 bit, FIFO can accept a nibble.
REQ-008 The block SHALL have port err_en, input, 1 bit, corrupt the next dequeued codeword.
REQ-009 The block SHALL have port err_pos, input, 3 bits, codeword bit index to flip (0..6).
REQ-010 The block SHALL have port tx_out, output, 1 bit, serial line, idle high.
REQ-011 The block SHALL have port tx_busy, output, 1 bit, frame in progress.
REQ-012 The block SHALL have port cw_last, output, 7 bits, codeword of the frame currently or last sent.

Function
REQ-013 Encoding SHALL be Hamming(7,4): cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[2]=d0, cw[3]=d1^d2^d3, cw[4]=d1, cw[5]=d2, cw[6]=d3.
REQ-014 A nibble SHALL be written into the FIFO on a rising edge where data_valid and data_ready are both 1; data_valid while data_ready=0 SHALL be ignored (no write, no overflow).
REQ-015 data_ready SHALL be 0 exactly when the FIFO holds DEPTH entries, registered-count based, no combinational path from data_valid.
REQ-016 FIFO read and write pointers SHALL wrap modulo DEPTH; a simultaneous write and read on a full FIFO SHALL NOT be allowed (data_ready=0 blocks the write), and on an empty FIFO the write SHALL land and be read no earlier than the next cycle.
REQ-017 The serializer FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 IDLE: tx_out=1, tx_busy=0; if FIFO non-empty, dequeue one entry, load encoded word into shift register and cw_last, go to START.
REQ-019 On dequeue, if err_en=1 and err_pos<=6, bit err_pos of the loaded word (and cw_last) SHALL be inverted; err_pos=7 SHALL inject nothing. err_en is sampled only at dequeue.
REQ-020 START SHALL drive tx_out=0 for BIT_DIV cycles, then DATA.
REQ-021 DATA SHALL send cw[0] first through cw[6], each for BIT_DIV cycles, then STOP.
REQ-022 STOP SHALL drive tx_out=1 for BIT_DIV cycles, then IDLE; a full frame is 9*BIT_DIV cycles.
REQ-023 tx_busy SHALL be 1 in START, DATA and STOP.
REQ-024 Back-to-back frames SHALL be separated by exactly one IDLE cycle at tx_out=1.
REQ-025 The bit-period counter SHALL be 8 bits, count 0..BIT_DIV-1 and reload to 0 on each bit boundary; the bit index counter SHALL be 3 bits, 0..6.
REQ-026 tx_out and tx_busy SHALL be driven directly from registers (glitch-free).

Reset
REQ-027 Asserting rst_n=0 at any time, including mid-frame, SHALL immediately set FSM=IDLE, FIFO empty, counters 0, tx_out=1, tx_busy=0, data_ready=1, cw_last=7'b0000000; a partial frame SHALL be abandoned, not resumed.
REQ-028 Reset release SHALL be synchronized internally so that the first FSM transition occurs no earlier than the second rising clk edge after rst_n rises.

Verification
REQ-029 Nibble 4'b1011, BIT_DIV=8 -> cw_last=7'b1010101; tx_out pattern 0,1,0,1,0,1,0,1,1 each held 8 cycles; tx_busy high 72 cycles.
REQ-030 All 16 nibbles sent -> each received frame decodes to input nibble, syndrome zero; nibble 0 -> 7'b0000000, nibble 4'hF -> 7'b1111111.
REQ-031 err_en=1, err_pos=3 with nibble 4'b1011 -> cw_last=7'b1011101; err_pos=7 -> 7'b1010101 unchanged.
REQ-032 Write 5 nibbles in 5 consecutive cycles while idle, DEPTH=4 -> first dequeued at once, data_ready stays 1 through 5 writes only if a dequeue occurred; 6th write attempt with FIFO full dropped, frames emitted in write order, one idle cycle between.
REQ-033 rst_n pulsed low during DATA bit 3 -> tx_out=1, tx_busy=0 same cycle, FIFO empty, cw_last=0; new nibble after release sends a complete clean frame.
REQ-034 BIT_DIV=1 -> frame of 9 cycles, contiguous frames at 10-cycle period with FIFO kept non-empty.
